idex_hazard_unit: RTL and testbench
===================================

// Module: idex_hazard_unit
// PURPOSE
// Consumer side of the ID/EX pipeline buffer: tracks every instruction issued into the
// double-registered ID/EX buffer and the stages behind it, detects load-use and in-flight
// RAW hazards for the instruction now in ID, and drives the stall/bubble controls back
// to IF/ID and to the ID/EX buffer inputs. It also produces forwarding selects for EX.
// PARAMETERS
// RD_W      6   register-specifier width (matches ID/EX Rd field)
// DEPTH     4   shadow-pipeline entries (ID/EX stage 1, stage 2, EX/MEM, MEM/WB)
// LOAD_LAT  3   entry index (0-based) from which a load result is forwardable
// CNT_W     16  stall-statistics counter width
// PORTS
// clock       in   1      rising-edge clock, same clock as ID/EX buffer
// rst_n       in   1      asynchronous active-low reset
// id_valid    in   1      ID holds a real instruction
// id_rs       in   RD_W   ID source register A
// id_rt       in   RD_W   ID source register B
// id_rs_used  in   1      source A is read
// id_rt_used  in   1      source B is read
// id_rd       in   RD_W   ID destination register
// id_wr       in   1      ID instruction writes id_rd
// id_load     in   1      ID instruction is a memory read (MEM control read bit)
// flush       in   1      branch taken: squash ID and ID/EX stage 1
// stall       out  1      freeze PC and IF/ID this cycle (combinational)
// bubble      out  1      force zero EX/MEM control into ID/EX inputs (combinational)
// fwd_a_sel   out  2      EX operand A: 0 regfile, 1 from EX/MEM, 2 from MEM/WB
// fwd_b_sel   out  2      EX operand B, same encoding
// stall_cnt   out  CNT_W  saturating count of stall cycles
// BEHAVIOUR
// - Shadow pipe: DEPTH entries {v, rd, wr, load}; each posedge shifts entry[i]->[i+1],
//   entry[0] <= ID instruction, or invalid when stall|flush|!id_valid.
// - Register 0 never matches (writes to r0 ignored; no hazard, no forwarding).
// - Hazard on source s (s_used=1): youngest valid entry i with wr && rd==s && i<DEPTH-1
//   and load && i<LOAD_LAT -> stall. Non-load producer at i<1 (still inside ID/EX double
//   buffer, result not yet computed) -> stall. Youngest match wins; older ignored.
// - stall=1 => bubble=1; stall held until producer reaches a forwardable entry
//   (load: up to LOAD_LAT cycles; ALU: 1 cycle).
// - flush: stall and bubble forced 0 same cycle; entry[0] and entry[1] invalidated on
//   next edge; older entries retire normally. flush overrides stall.
// - Forwarding (registered with EX view): fwd_x_sel=1 if entry[DEPTH-2] matches,
//   else 2 if entry[DEPTH-1] matches, else 0; EX/MEM priority over MEM/WB.
// - stall_cnt increments on each cycle stall=1; saturates at all-ones, never wraps.
// - Reset (async, rst_n=0): all entries invalid, fwd sels 0, stall_cnt 0; stall/bubble
//   evaluate to 0. Reset mid-stall drops the stall immediately; no pending state kept.
// - id_valid=0: no hazard check, stall=0, bubble inserted into shadow pipe.
// STRUCTURE
// - Shared package: RD_W, fwd select encodings (FWD_RF/FWD_EXMEM/FWD_MEMWB), shadow
//   entry struct {v, rd, wr, load}, zero-register constant.
// - One sub-module: hazard_match (combinational compare of one source vs all entries,
//   returns stall flag and forwarding select); instantiated for rs and rt.
// TESTING
// - Load r5 then ADD r6,r5,r1 next cycle -> stall=1 for 3 cycles, bubble=1 same, then
//   fwd_a_sel=2 on consume; stall_cnt=3.
// - ADD r3 then SUB uses r3,r3 next cycle -> stall 1 cycle, then fwd_a_sel=fwd_b_sel=1.
// - Load r0 then use r0 -> stall never asserts; fwd sels stay 0.
// - Load r7, use r7, flush asserted in 2nd stall cycle -> stall=0 that cycle; entries 0-1
//   invalid next edge; later r7 consumer sees no stale match from flushed entries.
// - Two writers of r4 in flight (ALU older, ALU younger) -> fwd select picks EX/MEM (1).
// - Force 2^CNT_W+5 stall cycles -> stall_cnt holds 0xFFFF; rst_n low mid-stall ->
//   stall, bubble, stall_cnt, fwd sels 0 without clock edge.

Source files
------------

// File: rtl/idex_hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// idex_hazard_unit_pkg
// Shared definitions for the ID/EX hazard unit.
//   RD_W          register-specifier width (ID/EX Rd field). The shadow entry
//                 struct is built from it, so it lives here rather than as a
//                 module parameter.
//   fwd_sel_e     EX operand source select: register file, EX/MEM, MEM/WB.
//   shadow_t      one shadow-pipeline entry {v, rd, wr, load}.
//   ZERO_REG      hard-wired zero register; never a hazard or forward source.
//   make_entry    packs an ID instruction into a shadow entry.
//   writes_reg    true when an entry will write a given (non-zero) register.
// -----------------------------------------------------------------------------
package idex_hazard_unit_pkg;

   localparam int RD_W = 6;

   typedef enum logic [1:0] {
      FWD_RF    = 2'd0,
      FWD_EXMEM = 2'd1,
      FWD_MEMWB = 2'd2
   } fwd_sel_e;

   typedef struct packed {
      logic            v;
      logic [RD_W-1:0] rd;
      logic            wr;
      logic            load;
   } shadow_t;

   localparam logic [RD_W-1:0] ZERO_REG = '0;

   function automatic shadow_t make_entry(input logic            valid,
                                          input logic [RD_W-1:0] rd,
                                          input logic            wr,
                                          input logic            load);
      shadow_t e;
      e.v    = valid;
      e.rd   = rd;
      e.wr   = wr;
      e.load = load;
      return e;
   endfunction

   // Writes to r0 are architecturally discarded, so an r0 destination never
   // produces anything a consumer could depend on.
   function automatic logic writes_reg(input shadow_t         e,
                                       input logic [RD_W-1:0] r);
      return e.v && e.wr && (e.rd == r) && (r != ZERO_REG);
   endfunction

endpackage

// File: rtl/idex_hazard_unit_hazard_match.sv
// -----------------------------------------------------------------------------
// hazard_match
// Compares one ID source register against every shadow-pipeline entry and
// decides whether the consumer must wait and, if not, where EX should pick
// the operand up from. Purely combinational.
// Ports:
//   i_src      source register specifier from ID
//   i_used     source is actually read by the ID instruction
//   i_entries  shadow pipeline, index 0 = youngest (ID/EX stage 1)
//   o_stall    youngest producer has not reached a forwardable entry yet
//   o_fwd      operand source if the consumer issues this cycle
// -----------------------------------------------------------------------------
module hazard_match
   import idex_hazard_unit_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int LOAD_LAT = 3
) (
   input  logic [RD_W-1:0]        i_src,
   input  logic                   i_used,
   input  shadow_t [DEPTH-1:0]    i_entries,
   output logic                   o_stall,
   output fwd_sel_e               o_fwd
);

   logic w_found;

   // Scan from youngest to oldest; only the first (youngest) producer counts,
   // older writers of the same register hold stale values.
   // A load is usable from entry LOAD_LAT, an ALU result from entry 1. The
   // oldest entry is never a hazard: its value is already on the MEM/WB path.
   // A producer in the last entry is taken from MEM/WB; anything younger that
   // is past its hazard window is taken from EX/MEM.
   always_comb begin
      o_stall = 1'b0;
      o_fwd   = FWD_RF;
      w_found = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (i_used && !w_found && writes_reg(i_entries[i], i_src)) begin
            w_found = 1'b1;
            if (i < DEPTH-1) begin
               if (i_entries[i].load) begin
                  o_stall = (i < LOAD_LAT);
               end else begin
                  o_stall = (i < 1);
               end
            end
            o_fwd = (i == DEPTH-1) ? FWD_MEMWB : FWD_EXMEM;
         end
      end
   end

endmodule

// File: rtl/idex_hazard_unit.sv
// -----------------------------------------------------------------------------
// idex_hazard_unit
// Consumer side of the double-registered ID/EX buffer. A shadow pipeline
// mirrors every instruction issued into ID/EX stage 1, stage 2, EX/MEM and
// MEM/WB; the instruction in ID is checked against it for load-use and
// in-flight RAW hazards, and forwarding selects are produced for EX.
// Ports:
//   clock                 rising-edge clock shared with the ID/EX buffer
//   rst_n                 asynchronous active-low reset
//   id_valid              ID holds a real instruction
//   id_rs / id_rt         ID source registers A / B
//   id_rs_used/id_rt_used source A / B is read
//   id_rd / id_wr         ID destination and its write enable
//   id_load               ID instruction is a memory read
//   flush                 branch taken: squash ID and ID/EX stage 1
//   stall                 freeze PC and IF/ID (combinational)
//   bubble                zero the EX/MEM controls entering ID/EX (combinational)
//   fwd_a_sel/fwd_b_sel   EX operand select: 0 regfile, 1 EX/MEM, 2 MEM/WB
//   stall_cnt             saturating count of stall cycles
// -----------------------------------------------------------------------------
module idex_hazard_unit
   import idex_hazard_unit_pkg::*;
#(
   parameter int DEPTH    = 4,
   parameter int LOAD_LAT = 3,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             id_valid,
   input  logic [RD_W-1:0]  id_rs,
   input  logic [RD_W-1:0]  id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [RD_W-1:0]  id_rd,
   input  logic             id_wr,
   input  logic             id_load,
   input  logic             flush,
   output logic             stall,
   output logic             bubble,
   output logic [1:0]       fwd_a_sel,
   output logic [1:0]       fwd_b_sel,
   output logic [CNT_W-1:0] stall_cnt
);

   shadow_t [DEPTH-1:0] r_entries;
   fwd_sel_e            r_fwd_a;
   fwd_sel_e            r_fwd_b;
   logic [CNT_W-1:0]    r_stall_cnt;

   logic                w_stall_a;
   logic                w_stall_b;
   fwd_sel_e            w_fwd_a;
   fwd_sel_e            w_fwd_b;
   logic                w_stall;
   logic                w_issue;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
      return (&c) ? c : c + CNT_W'(1);
   endfunction

   hazard_match #(
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT)
   ) u_match_a (
      .i_src     (id_rs),
      .i_used    (id_rs_used),
      .i_entries (r_entries),
      .o_stall   (w_stall_a),
      .o_fwd     (w_fwd_a)
   );

   hazard_match #(
      .DEPTH    (DEPTH),
      .LOAD_LAT (LOAD_LAT)
   ) u_match_b (
      .i_src     (id_rt),
      .i_used    (id_rt_used),
      .i_entries (r_entries),
      .o_stall   (w_stall_b),
      .o_fwd     (w_fwd_b)
   );

   // A taken branch kills the ID instruction, so it can never be stalled.
   // Reset clears the shadow pipe asynchronously, which drops any stall
   // without waiting for a clock edge.
   assign w_stall = id_valid && (w_stall_a || w_stall_b) && !flush;
   assign w_issue = id_valid && !w_stall && !flush;

   assign stall     = w_stall;
   assign bubble    = w_stall;
   assign fwd_a_sel = r_fwd_a;
   assign fwd_b_sel = r_fwd_b;
   assign stall_cnt = r_stall_cnt;

   // Shadow pipeline advance. On flush the new stage-1 and stage-2 entries
   // are empty (ID and the old stage 1 are squashed); the old stage 2 and
   // everything behind it keep moving and retire normally.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_entries <= '0;
      end else begin
         for (int i = DEPTH-1; i > 0; i--) begin
            r_entries[i] <= r_entries[i-1];
         end
         if (flush) begin
            r_entries[1] <= '0;
         end
         r_entries[0] <= w_issue ? make_entry(1'b1, id_rd, id_wr, id_load)
                                 : '0;
      end
   end

   // Forwarding selects travel with the issued instruction into EX; a stall
   // or squash sends a bubble, which needs no forwarding.
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_fwd_a <= FWD_RF;
         r_fwd_b <= FWD_RF;
      end else begin
         r_fwd_a <= w_issue ? w_fwd_a : FWD_RF;
         r_fwd_b <= w_issue ? w_fwd_b : FWD_RF;
      end
   end

   // Stall statistics
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (w_stall) begin
         r_stall_cnt <= sat_inc(r_stall_cnt);
      end
   end

endmodule

// File: tb/tb_idex_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_idex_hazard_unit
// Directed scenarios for idex_hazard_unit. A second instance with a 4-bit
// stall counter shares all inputs so counter saturation is reached quickly.
// -----------------------------------------------------------------------------
module tb_idex_hazard_unit;
   import idex_hazard_unit_pkg::*;

   logic             clock = 1'b0;
   logic             rst_n;
   logic             id_valid;
   logic [RD_W-1:0]  id_rs;
   logic [RD_W-1:0]  id_rt;
   logic             id_rs_used;
   logic             id_rt_used;
   logic [RD_W-1:0]  id_rd;
   logic             id_wr;
   logic             id_load;
   logic             flush;

   logic             stall;
   logic             bubble;
   logic [1:0]       fwd_a_sel;
   logic [1:0]       fwd_b_sel;
   logic [15:0]      stall_cnt;

   logic             s_stall;
   logic             s_bubble;
   logic [1:0]       s_fwd_a;
   logic [1:0]       s_fwd_b;
   logic [3:0]       s_cnt;

   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   idex_hazard_unit #(.DEPTH(4), .LOAD_LAT(3), .CNT_W(16)) dut (
      .clock      (clock),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .id_rd      (id_rd),
      .id_wr      (id_wr),
      .id_load    (id_load),
      .flush      (flush),
      .stall      (stall),
      .bubble     (bubble),
      .fwd_a_sel  (fwd_a_sel),
      .fwd_b_sel  (fwd_b_sel),
      .stall_cnt  (stall_cnt)
   );

   idex_hazard_unit #(.DEPTH(4), .LOAD_LAT(3), .CNT_W(4)) dut_sat (
      .clock      (clock),
      .rst_n      (rst_n),
      .id_valid   (id_valid),
      .id_rs      (id_rs),
      .id_rt      (id_rt),
      .id_rs_used (id_rs_used),
      .id_rt_used (id_rt_used),
      .id_rd      (id_rd),
      .id_wr      (id_wr),
      .id_load    (id_load),
      .flush      (flush),
      .stall      (s_stall),
      .bubble     (s_bubble),
      .fwd_a_sel  (s_fwd_a),
      .fwd_b_sel  (s_fwd_b),
      .stall_cnt  (s_cnt)
   );

   task automatic set_id(input logic v, input logic [RD_W-1:0] rs, input logic rsu,
                         input logic [RD_W-1:0] rt, input logic rtu,
                         input logic [RD_W-1:0] rd, input logic wr, input logic ld);
      id_valid   = v;
      id_rs      = rs;
      id_rs_used = rsu;
      id_rt      = rt;
      id_rt_used = rtu;
      id_rd      = rd;
      id_wr      = wr;
      id_load    = ld;
   endtask

   task automatic idle();
      set_id(1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0);
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      idle();
      flush = 1'b0;
      next_cycle();
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      flush = 1'b0;
      set_id(1'b1, 6'd2, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1);
      #2;
      checks++;
      if (stall !== 1'b0 || bubble !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: stall=%b bubble=%b expected 0 0", stall, bubble);
      end
      checks++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL reset_state: fwd_a=%0d fwd_b=%0d cnt=%0d expected 0 0 0",
                  fwd_a_sel, fwd_b_sel, stall_cnt);
      end
      next_cycle();
      rst_n = 1'b1;
      // LW r5 issues now; consumer follows, then a reset pulse mid-cycle
      next_cycle();
      set_id(1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 6'd6, 1'b1, 1'b0);
      @(negedge clock);
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL reset_pre_stall: stall=%b expected 1", stall);
      end
      #1 rst_n = 1'b0;
      #1 rst_n = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || bubble !== 1'b0) begin
         errors++;
         $display("FAIL reset_drops_pending: stall=%b bubble=%b expected 0 0", stall, bubble);
      end
   endtask

   task automatic test_load_use();
      do_reset();
      set_id(1'b1, 6'd2, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1);   // LW r5
      @(negedge clock);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL load_use_first: stall=%b expected 0", stall);
      end
      next_cycle();
      set_id(1'b1, 6'd5, 1'b1, 6'd1, 1'b1, 6'd6, 1'b1, 1'b0);   // ADD r6,r5,r1
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checks++;
         if (stall !== 1'b1 || bubble !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall c%0d: stall=%b bubble=%b expected 1 1", k, stall, bubble);
         end
         next_cycle();
      end
      @(negedge clock);
      checks++;
      if (stall !== 1'b0 || bubble !== 1'b0 || fwd_a_sel !== 2'd0) begin
         errors++;
         $display("FAIL load_use_release: stall=%b bubble=%b fwd_a=%0d expected 0 0 0",
                  stall, bubble, fwd_a_sel);
      end
      next_cycle();
      idle();
      @(negedge clock);
      checks++;
      if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd0) begin
         errors++;
         $display("FAIL load_use_fwd: fwd_a=%0d fwd_b=%0d expected 2 0", fwd_a_sel, fwd_b_sel);
      end
      checks++;
      if (stall_cnt !== 16'd3) begin
         errors++;
         $display("FAIL load_use_cnt: stall_cnt=%0d expected 3", stall_cnt);
      end
      next_cycle();
      @(negedge clock);
      checks++;
      if (fwd_a_sel !== 2'd0) begin
         errors++;
         $display("FAIL load_use_fwd_clear: fwd_a=%0d expected 0", fwd_a_sel);
      end
   endtask

   task automatic test_alu_use();
      do_reset();
      set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd3, 1'b1, 1'b0);   // ADD r3,r1,r2
      next_cycle();
      set_id(1'b1, 6'd3, 1'b1, 6'd3, 1'b1, 6'd9, 1'b1, 1'b0);   // SUB r9,r3,r3
      @(negedge clock);
      checks++;
      if (stall !== 1'b1 || bubble !== 1'b1) begin
         errors++;
         $display("FAIL alu_use_stall: stall=%b bubble=%b expected 1 1", stall, bubble);
      end
      next_cycle();
      @(negedge clock);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL alu_use_release: stall=%b expected 0", stall);
      end
      next_cycle();
      idle();
      @(negedge clock);
      checks++;
      if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd1) begin
         errors++;
         $display("FAIL alu_use_fwd: fwd_a=%0d fwd_b=%0d expected 1 1", fwd_a_sel, fwd_b_sel);
      end
      checks++;
      if (stall_cnt !== 16'd1) begin
         errors++;
         $display("FAIL alu_use_cnt: stall_cnt=%0d expected 1", stall_cnt);
      end
   endtask

   task automatic test_r0();
      do_reset();
      set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b1, 1'b1);   // LW r0
      next_cycle();
      set_id(1'b1, 6'd0, 1'b1, 6'd0, 1'b1, 6'd2, 1'b1, 1'b0);   // uses r0,r0
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         checks++;
         if (stall !== 1'b0) begin
            errors++;
            $display("FAIL r0_no_stall c%0d: stall=%b expected 0", k, stall);
         end
         next_cycle();
      end
      idle();
      @(negedge clock);
      checks++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0 || stall_cnt !== 16'd0) begin
         errors++;
         $display("FAIL r0_no_fwd: fwd_a=%0d fwd_b=%0d cnt=%0d expected 0 0 0",
                  fwd_a_sel, fwd_b_sel, stall_cnt);
      end
   endtask

   task automatic test_unused_and_invalid();
      do_reset();
      set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 1'b1);   // LW r5
      next_cycle();
      set_id(1'b1, 6'd5, 1'b0, 6'd5, 1'b0, 6'd0, 1'b0, 1'b0);   // r5 named, not read
      @(negedge clock);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL unused_src: stall=%b expected 0", stall);
      end
      next_cycle();
      set_id(1'b0, 6'd5, 1'b1, 6'd5, 1'b1, 6'd0, 1'b0, 1'b0);   // not a real instruction
      @(negedge clock);
      checks++;
      if (stall !== 1'b0 || bubble !== 1'b0) begin
         errors++;
         $display("FAIL invalid_id: stall=%b bubble=%b expected 0 0", stall, bubble);
      end
      checks++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin
         errors++;
         $display("FAIL unused_fwd: fwd_a=%0d fwd_b=%0d expected 0 0", fwd_a_sel, fwd_b_sel);
      end
      next_cycle();
      set_id(1'b1, 6'd0, 1'b0, 6'd5, 1'b1, 6'd7, 1'b1, 1'b0);   // reads r5 on B
      @(negedge clock);
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL rt_load_stall: stall=%b expected 1", stall);
      end
      next_cycle();
      @(negedge clock);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL rt_load_release: stall=%b expected 0", stall);
      end
      next_cycle();
      idle();
      @(negedge clock);
      checks++;
      if (fwd_b_sel !== 2'd2 || fwd_a_sel !== 2'd0) begin
         errors++;
         $display("FAIL rt_load_fwd: fwd_a=%0d fwd_b=%0d expected 0 2", fwd_a_sel, fwd_b_sel);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1, 1'b1);   // LW r7
      next_cycle();
      set_id(1'b1, 6'd7, 1'b1, 6'd0, 1'b0, 6'd8, 1'b1, 1'b0);   // uses r7
      @(negedge clock);
      checks++;
      if (stall !== 1'b1) begin
         errors++;
         $display("FAIL flush_pre_stall: stall=%b expected 1", stall);
      end
      next_cycle();
      flush = 1'b1;
      @(negedge clock);
      checks++;
      if (stall !== 1'b0 || bubble !== 1'b0) begin
         errors++;
         $display("FAIL flush_overrides: stall=%b bubble=%b expected 0 0", stall, bubble);
      end
      next_cycle();
      flush = 1'b0;
      idle();
      @(negedge clock);
      checks++;
      if (stall_cnt !== 16'd1) begin
         errors++;
         $display("FAIL flush_cnt: stall_cnt=%0d expected 1", stall_cnt);
      end
      // writer squashed in stage 1 and another in ID must leave no trace
      do_reset();
      set_id(1'b1, 6'd1, 1'b1, 6'd0, 1'b0, 6'd7, 1'b1, 1'b1);   // LW r7
      next_cycle();
      flush = 1'b1;                                              // LW r7 again, squashed
      @(negedge clock);
      next_cycle();
      flush = 1'b0;
      set_id(1'b1, 6'd7, 1'b1, 6'd7, 1'b1, 6'd8, 1'b1, 1'b0);   // uses r7,r7
      @(negedge clock);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL flush_no_stale: stall=%b expected 0", stall);
      end
      next_cycle();
      idle();
      @(negedge clock);
      checks++;
      if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin
         errors++;
         $display("FAIL flush_no_stale_fwd: fwd_a=%0d fwd_b=%0d expected 0 0", fwd_a_sel, fwd_b_sel);
      end
   endtask

   task automatic test_two_writers();
      do_reset();
      set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 1'b1, 1'b0);   // ADD r4 (older)
      next_cycle();
      set_id(1'b1, 6'd2, 1'b1, 6'd0, 1'b0, 6'd4, 1'b1, 1'b0);   // ADD r4 (younger)
      next_cycle();
      idle();
      next_cycle();
      next_cycle();
      set_id(1'b1, 6'd4, 1'b1, 6'd10, 1'b1, 6'd11, 1'b1, 1'b0);
      @(negedge clock);
      checks++;
      if (stall !== 1'b0) begin
         errors++;
         $display("FAIL two_writers_stall: stall=%b expected 0", stall);
      end
      next_cycle();
      idle();
      @(negedge clock);
      checks++;
      if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd0) begin
         errors++;
         $display("FAIL two_writers_fwd: fwd_a=%0d fwd_b=%0d expected 1 0", fwd_a_sel, fwd_b_sel);
      end
      // single ALU writer that has reached MEM/WB
      do_reset();
      set_id(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd4, 1'b1, 1'b0);   // ADD r4
      next_cycle();
      idle();
      next_cycle();
      next_cycle();
      next_cycle();
      set_id(1'b1, 6'd11, 1'b1, 6'd4, 1'b1, 6'd12, 1'b1, 1'b0);
      next_cycle();
      idle();
      @(negedge clock);
      checks++;
      if (fwd_b_sel !== 2'd2 || fwd_a_sel !== 2'd0) begin
         errors++;
         $display("FAIL memwb_fwd: fwd_a=%0d fwd_b=%0d expected 0 2", fwd_a_sel, fwd_b_sel);
      end
   endtask

   task automatic test_saturation_and_reset();
      do_reset();
      // LW r8 reading r8, held: issue once every 4 cycles, stall in between
      set_id(1'b1, 6'd8, 1'b1, 6'd0, 1'b0, 6'd8, 1'b1, 1'b1);
      for (int k = 0; k <= 40; k++) begin
         @(negedge clock);
         checks++;
         if (stall !== ((k % 4) != 0)) begin
            errors++;
            $display("FAIL sat_pattern c%0d: stall=%b expected %b", k, stall, ((k % 4) != 0));
         end
         if (k < 40) next_cycle();
      end
      checks++;
      if (s_cnt !== 4'hF) begin
         errors++;
         $display("FAIL sat_hold: stall_cnt=%0h expected f", s_cnt);
      end
      checks++;
      if (stall_cnt !== 16'd30) begin
         errors++;
         $display("FAIL sat_wide_cnt: stall_cnt=%0d expected 30", stall_cnt);
      end
      next_cycle();
      @(negedge clock);
      checks++;
      if (stall !== 1'b1 || fwd_a_sel !== 2'd2) begin
         errors++;
         $display("FAIL sat_pre_reset: stall=%b fwd_a=%0d expected 1 2", stall, fwd_a_sel);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (stall !== 1'b0 || bubble !== 1'b0 || s_stall !== 1'b0 || s_bubble !== 1'b0) begin
         errors++;
         $display("FAIL async_reset_ctrl: stall=%b bubble=%b s_stall=%b s_bubble=%b expected 0",
                  stall, bubble, s_stall, s_bubble);
      end
      checks++;
      if (stall_cnt !== 16'd0 || s_cnt !== 4'd0 || fwd_a_sel !== 2'd0 ||
          fwd_b_sel !== 2'd0 || s_fwd_a !== 2'd0 || s_fwd_b !== 2'd0) begin
         errors++;
         $display("FAIL async_reset_regs: cnt=%0d s_cnt=%0d fwd_a=%0d fwd_b=%0d expected 0",
                  stall_cnt, s_cnt, fwd_a_sel, fwd_b_sel);
      end
      #1 rst_n = 1'b1;
      idle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_load_use();
      test_alu_use();
      test_r0();
      test_unused_and_invalid();
      test_flush();
      test_two_writers();
      test_saturation_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
